// File: rtl/axis_insert_header_mb.sv
// Prepends a multi-beat header packet (s00) to a payload packet (s01). Bytes are
// realigned into a dense output stream (m) held in a single output register stage.
module axis_insert_header_mb #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned CNT_WD       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s00_axis_tvalid,
  input  logic [DATA_WD-1:0]      s00_axis_tdata,
  input  logic [DATA_BYTE_WD-1:0] s00_axis_tkeep,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  input  logic                    s01_axis_tvalid,
  input  logic [DATA_WD-1:0]      s01_axis_tdata,
  input  logic [DATA_BYTE_WD-1:0] s01_axis_tkeep,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [DATA_WD-1:0]      m_axis_tdata,
  output logic [DATA_BYTE_WD-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [CNT_WD-1:0]       pkt_cnt
);

  localparam int unsigned KW = $clog2(DATA_BYTE_WD + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, FLUSH} state_t;

  // Keep vector with the n most significant lanes set (n may equal DATA_BYTE_WD).
  function automatic logic [DATA_BYTE_WD-1:0] msb_mask(input logic [KW:0] n);
    return ~({DATA_BYTE_WD{1'b1}} >> n);
  endfunction

  function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] msk;
    msk = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) msk[8*i +: 8] = {8{keep[i]}};
    return msk;
  endfunction

  state_t               state, state_nxt;
  logic [DATA_WD-1:0]   r, r_nxt;
  logic [KW-1:0]        k, k_nxt;
  logic [KW-1:0]        k_in, m_in;
  logic [KW:0]          sum;
  logic                 out_free, s00_fire, s01_fire, fits;
  logic [DATA_WD-1:0]   first_data, r_load, pay, src;
  logic [2*DATA_WD-1:0] cat;
  logic                 load_c, o_last;
  logic [DATA_WD-1:0]   o_data;
  logic [DATA_BYTE_WD-1:0] o_keep;

  assign out_free        = !m_axis_tvalid || m_axis_tready;
  assign s00_axis_tready = !rst && (state == IDLE || (state == HDR && out_free));
  assign s01_axis_tready = !rst && state == DATA && out_free;
  assign s00_fire        = s00_axis_tvalid && s00_axis_tready;
  assign s01_fire        = s01_axis_tvalid && s01_axis_tready;

  // Byte counts of the header first beat and the payload last beat.
  always_comb begin
    k_in = '0;
    m_in = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) begin
      k_in = k_in + KW'(s00_axis_tkeep[i]);
      m_in = m_in + KW'(s01_axis_tkeep[i]);
    end
  end

  // Residual bytes R sit left-aligned in r; the incoming beat is appended right after them.
  assign first_data = s00_axis_tdata & lane_mask(s00_axis_tkeep);
  assign r_load     = first_data << {KW'(DATA_BYTE_WD) - k_in, 3'b000};
  assign pay        = s01_axis_tlast ? (s01_axis_tdata & lane_mask(s01_axis_tkeep)) : s01_axis_tdata;
  assign src        = (state == HDR) ? s00_axis_tdata : pay;
  assign cat        = {r, DATA_WD'(0)} | ({src, DATA_WD'(0)} >> {k, 3'b000});
  assign sum        = {1'b0, k} + {1'b0, m_in};
  assign fits       = sum <= (KW + 1)'(DATA_BYTE_WD);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s00_fire) state_nxt = s00_axis_tlast ? DATA : HDR;
      HDR:     if (s00_fire && s00_axis_tlast) state_nxt = DATA;
      DATA:    if (s01_fire && s01_axis_tlast) state_nxt = fits ? IDLE : FLUSH;
      FLUSH:   if (out_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_c = 1'b0;
    o_data = '0;
    o_keep = '0;
    o_last = 1'b0;
    r_nxt  = r;
    k_nxt  = k;
    case (state)
      IDLE: if (s00_fire) begin
        r_nxt = r_load;
        k_nxt = k_in;
      end
      HDR: if (s00_fire) begin
        load_c = 1'b1;
        o_data = cat[2*DATA_WD-1 -: DATA_WD];
        o_keep = '1;
        r_nxt  = cat[DATA_WD-1:0];
      end
      DATA: if (s01_fire) begin
        load_c = 1'b1;
        o_data = cat[2*DATA_WD-1 -: DATA_WD];
        if (s01_axis_tlast && fits) begin
          o_keep = msb_mask(sum);
          o_last = 1'b1;
        end else begin
          o_keep = '1;
          r_nxt  = cat[DATA_WD-1:0];
          if (s01_axis_tlast) k_nxt = KW'(sum - (KW + 1)'(DATA_BYTE_WD));
        end
      end
      FLUSH: if (out_free) begin
        load_c = 1'b1;
        o_data = r;
        o_keep = msb_mask({1'b0, k});
        o_last = 1'b1;
      end
      default: ;
    endcase
  end

  // Residual buffer, output register and packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r             <= '0;
      k             <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_cnt       <= '0;
    end else begin
      r <= r_nxt;
      k <= k_nxt;
      if (out_free) begin
        m_axis_tvalid <= load_c;
        m_axis_tdata  <= o_data;
        m_axis_tkeep  <= o_keep;
        m_axis_tlast  <= o_last;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_cnt <= pkt_cnt + CNT_WD'(1);
    end
  end

endmodule

// File: tb/tb_axis_insert_header_mb.sv
// Directed bench for axis_insert_header_mb: scripted header/payload packets,
// output beats collected and compared against hand-computed expectations.
module tb_axis_insert_header_mb;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s00_tvalid = 1'b0, s00_tlast = 1'b0, s00_tready;
  logic [DW-1:0] s00_tdata = '0;
  logic [BW-1:0] s00_tkeep = '0;
  logic          s01_tvalid = 1'b0, s01_tlast = 1'b0, s01_tready;
  logic [DW-1:0] s01_tdata = '0;
  logic [BW-1:0] s01_tkeep = '0;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b1;
  logic [DW-1:0] m_tdata;
  logic [BW-1:0] m_tkeep;
  logic [CW-1:0] pkt_cnt;

  beat_t q00[$], q01[$], qexp[$], qout[$];
  int    n_tests = 0, n_fail = 0;
  logic  acc00 = 1'b0, acc01 = 1'b0;
  logic  gap_en = 1'b0, tog_en = 1'b0, stab_en = 1'b0;
  logic  held_v = 1'b0;
  logic [37:0] held = '0;

  axis_insert_header_mb #(.DATA_WD(DW), .DATA_BYTE_WD(BW), .CNT_WD(CW)) dut (
    .clk(clk), .rst(rst),
    .s00_axis_tvalid(s00_tvalid), .s00_axis_tdata(s00_tdata), .s00_axis_tkeep(s00_tkeep),
    .s00_axis_tlast(s00_tlast), .s00_axis_tready(s00_tready),
    .s01_axis_tvalid(s01_tvalid), .s01_axis_tdata(s01_tdata), .s01_axis_tkeep(s01_tkeep),
    .s01_axis_tlast(s01_tlast), .s01_axis_tready(s01_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Header driver: handshake sampled at negedge, inputs updated after posedge.
  always begin
    @(negedge clk);
    acc00 = s00_tvalid && s00_tready;
    @(posedge clk);
    #1;
    if (acc00 && q00.size() > 0) void'(q00.pop_front());
    if (q00.size() > 0) begin
      s00_tvalid = 1'b1;
      {s00_tdata, s00_tkeep, s00_tlast} = q00[0];
    end else s00_tvalid = 1'b0;
  end

  // Payload driver with optional idle gaps between beats.
  always begin
    @(negedge clk);
    acc01 = s01_tvalid && s01_tready;
    @(posedge clk);
    #1;
    if (acc01 && q01.size() > 0) void'(q01.pop_front());
    if (q01.size() == 0) s01_tvalid = 1'b0;
    else if (s01_tvalid && !acc01) s01_tvalid = 1'b1;
    else if (gap_en && $urandom_range(0, 1) == 0) s01_tvalid = 1'b0;
    else begin
      s01_tvalid = 1'b1;
      {s01_tdata, s01_tkeep, s01_tlast} = q01[0];
    end
  end

  always @(posedge clk) begin
    #1;
    m_tready = tog_en ? !m_tready : 1'b1;
  end

  // Output collector and stall-stability monitor.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) qout.push_back(beat_t'({m_tdata, m_tkeep, m_tlast}));
    if (stab_en && held_v) check("stall_hold", 64'({m_tvalid, m_tdata, m_tkeep, m_tlast}), 64'(held));
    held_v = !rst && m_tvalid && !m_tready;
    held   = {m_tvalid, m_tdata, m_tkeep, m_tlast};
  end

  task automatic h(input logic [31:0] d, input logic [3:0] k, input logic l);
    q00.push_back(beat_t'({d, k, l}));
  endtask
  task automatic p(input logic [31:0] d, input logic [3:0] k, input logic l);
    q01.push_back(beat_t'({d, k, l}));
  endtask
  task automatic e(input logic [31:0] d, input logic [3:0] k, input logic l);
    qexp.push_back(beat_t'({d, k, l}));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q00.delete();
    q01.delete();
    s00_tvalid = 1'b0;
    s01_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    qout.delete();
  endtask

  task automatic run_check(input string name, input int budget, input int cnt);
    int n = 0;
    while (qout.size() < qexp.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({name, "_beats"}, 64'(qout.size()), 64'(qexp.size()));
    foreach (qexp[i]) begin
      if (i < qout.size()) begin
        check({name, "_data"}, 64'(qout[i].d), 64'(qexp[i].d));
        check({name, "_keep"}, 64'(qout[i].k), 64'(qexp[i].k));
        check({name, "_last"}, 64'(qout[i].l), 64'(qexp[i].l));
      end
    end
    check({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(cnt));
    qexp.delete();
    qout.delete();
  endtask

  task automatic scen1();
    h(32'h11223344, 4'b0011, 1'b1);
    p(32'hA0A1A2A3, 4'b1111, 1'b0);
    p(32'hB0B1B2B3, 4'b1100, 1'b1);
    e(32'h3344A0A1, 4'b1111, 1'b0);
    e(32'hA2A3B0B1, 4'b1111, 1'b1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_tkeep", 64'(m_tkeep), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_s00_ready", 64'(s00_tready), 64'd0);
    check("rst_s01_ready", 64'(s01_tready), 64'd0);
    do_reset();
    #1;
    check("post_rst_s00_ready", 64'(s00_tready), 64'd1);

    scen1();
    run_check("s1", 200, 1);

    h(32'h01020304, 4'b1111, 1'b0);
    h(32'h05060708, 4'b1111, 1'b1);
    p(32'hAABBCCDD, 4'b1000, 1'b1);
    e(32'h01020304, 4'b1111, 1'b0);
    e(32'h05060708, 4'b1111, 1'b0);
    e(32'hAA000000, 4'b1000, 1'b1);
    run_check("s2_flush", 200, 2);

    h(32'h000000EE, 4'b0001, 1'b1);
    p(32'h11223344, 4'b1111, 1'b1);
    e(32'hEE112233, 4'b1111, 1'b0);
    e(32'h44000000, 4'b1000, 1'b1);
    run_check("s3", 200, 3);

    tog_en  = 1'b1;
    gap_en  = 1'b1;
    stab_en = 1'b1;
    scen1();
    run_check("s4_stall", 400, 4);
    tog_en  = 1'b0;
    gap_en  = 1'b0;
    stab_en = 1'b0;
    repeat (2) @(posedge clk);

    // Reset right after the second header beat of scenario 2 is taken.
    begin
      int n = 0;
      h(32'h01020304, 4'b1111, 1'b0);
      h(32'h05060708, 4'b1111, 1'b1);
      while (q00.size() > 0 && n < 100) begin
        @(posedge clk);
        #2;
        n++;
      end
      check("mid_rst_drain", 64'(q00.size()), 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
      check("mid_rst_tdata", 64'(m_tdata), 64'd0);
      check("mid_rst_tkeep", 64'(m_tkeep), 64'd0);
      check("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      check("mid_rst_s00_ready", 64'(s00_tready), 64'd0);
      rst = 1'b0;
      #1;
      check("mid_rst_idle", 64'(s00_tready), 64'd1);
      qout.delete();
      qexp.delete();
    end
    scen1();
    run_check("s5_after_rst", 200, 1);

    do_reset();
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      h(32'(i) | 32'h5A000000, 4'b1111, 1'b1);
      p(~32'(i), 4'b1111, 1'b1);
      e(32'(i) | 32'h5A000000, 4'b1111, 1'b0);
      e(~32'(i), 4'b1111, 1'b1);
    end
    run_check("wrap", 5000, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
